// File: rtl/pio_pkg.sv
// Shared constants for the PIO input peripheral: register addresses and
// edge-capture mode encodings.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_MODE    = 2'd3;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit pad conditioner: 2-FF synchroniser, polarity fix-up and a
// consecutive-cycle counter debouncer (bypassed when DEBOUNCE_CYCLES is 0).
module pio_debounce
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b1,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic stable
);

  logic sync1_q, sync2_q, syn;

  // Reset to the idle pad level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INVERT;
      sync2_q <= INVERT;
    end else begin
      sync1_q <= pad;
      sync2_q <= sync1_q;
    end
  end

  assign syn = sync2_q ^ INVERT;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign stable = syn;
  end else begin : g_count
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (syn == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= syn;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign stable = stable_q;
  end

endmodule

// File: rtl/pio_in_edge.sv
// Debounced general-purpose input PIO with Avalon-MM register file,
// per-bit edge capture (rise/fall/any) and a maskable level interrupt.
module pio_in_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pio_export
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] stable, prev_q, rise, fall, cap, clr;
  logic [WIDTH-1:0] edgecap_q, edgecap_d, irqmask_q;
  logic [1:0]       mode_q;
  logic [31:0]      rdata_d;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .pad   (pio_export[i]),
      .stable(stable[i])
    );
  end

  always_comb begin
    rise = stable & ~prev_q;
    fall = ~stable & prev_q;
    case (mode_q)
      MODE_RISE: cap = rise;
      MODE_FALL: cap = fall;
      MODE_ANY:  cap = rise | fall;
      default:   cap = '0;
    endcase
    clr = (avs_write && (avs_address == ADDR_EDGECAP)) ? avs_writedata[WIDTH-1:0] : '0;
    // A fresh capture beats a same-cycle clear so no edge is ever dropped.
    edgecap_d = (edgecap_q & ~clr) | cap;
  end

  always_comb begin
    rdata_d = '0;
    case (avs_address)
      ADDR_DATA:    rdata_d = 32'(stable);
      ADDR_IRQMASK: rdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: rdata_d = 32'(edgecap_q);
      ADDR_MODE:    rdata_d = 32'(mode_q);
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev_q       <= '0;
      edgecap_q    <= '0;
      irqmask_q    <= '0;
      mode_q       <= MODE_RISE;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      prev_q    <= stable;
      edgecap_q <= edgecap_d;
      irq       <= |(edgecap_q & irqmask_q);
      if (avs_read) begin
        avs_readdata <= rdata_d;
      end
      if (avs_write && (avs_address == ADDR_IRQMASK)) begin
        irqmask_q <= avs_writedata[WIDTH-1:0];
      end
      if (avs_write && (avs_address == ADDR_MODE)) begin
        mode_q <= avs_writedata[1:0];
      end
    end
  end

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed bench for two pio_in_edge instances (buttons: 4/8/inverted,
// switches: 10/bypass/non-inverted) checked every cycle against a model.
module tb_pio_in_edge;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_CAP  = 2'd2;
  localparam logic [1:0] A_MODE = 2'd3;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        irq_w [2];
  logic [3:0]  pad_a;
  logic [9:0]  pad_b;

  int tests = 0;
  int errors = 0;

  pio_in_edge #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .INVERT(1'b1)) u_dut_a (
    .clk_clk      (clk),
    .reset_reset_n(rst_n[0]),
    .avs_address  (addr[0]),
    .avs_read     (rd[0]),
    .avs_write    (wr[0]),
    .avs_writedata(wdata[0]),
    .avs_readdata (rdata[0]),
    .irq          (irq_w[0]),
    .pio_export   (pad_a)
  );

  pio_in_edge #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .INVERT(1'b0)) u_dut_b (
    .clk_clk      (clk),
    .reset_reset_n(rst_n[1]),
    .avs_address  (addr[1]),
    .avs_read     (rd[1]),
    .avs_write    (wr[1]),
    .avs_writedata(wdata[1]),
    .avs_readdata (rdata[1]),
    .irq          (irq_w[1]),
    .pio_export   (pad_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state. hist[i][31] is the active-high pad sample taken at the most
  // recent edge, hist[i][31-j] the one taken j edges earlier.
  logic [9:0]  hist     [2][32];
  logic [9:0]  m_stable [2];
  logic [9:0]  m_prev   [2];
  logic [9:0]  m_cap    [2];
  logic [9:0]  m_mask   [2];
  logic [1:0]  m_mode   [2];
  logic        m_irq    [2];
  logic [31:0] m_rd     [2];

  function automatic int dcyc(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic logic [9:0] wmask(input int i);
    return (i == 0) ? 10'h00F : 10'h3FF;
  endfunction

  function automatic logic [9:0] invm(input int i);
    return (i == 0) ? 10'h00F : 10'h000;
  endfunction

  task automatic model_reset(input int i);
    for (int k = 0; k < 32; k++) hist[i][k] = '0;
    m_stable[i] = '0;
    m_prev[i]   = '0;
    m_cap[i]    = '0;
    m_mask[i]   = '0;
    m_mode[i]   = 2'b01;
    m_irq[i]    = 1'b0;
    m_rd[i]     = '0;
  endtask

  task automatic model_step(input int i, input logic [9:0] pad, input logic r, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
    logic [9:0] ns, a1, o1, rise, fall, capv, clr;
    for (int k = 0; k < 31; k++) hist[i][k] = hist[i][k+1];
    hist[i][31] = (pad ^ invm(i)) & wmask(i);
    // A bit takes a new level once the last D synchronised samples all agree.
    if (dcyc(i) == 0) begin
      ns = hist[i][30];
    end else begin
      a1 = wmask(i);
      o1 = '0;
      for (int j = 2; j <= dcyc(i) + 1; j++) begin
        a1 = a1 & hist[i][31-j];
        o1 = o1 | hist[i][31-j];
      end
      ns = (m_stable[i] & o1) | a1;
    end
    rise = m_stable[i] & ~m_prev[i];
    fall = ~m_stable[i] & m_prev[i];
    case (m_mode[i])
      2'b01:   capv = rise;
      2'b10:   capv = fall;
      2'b11:   capv = rise | fall;
      default: capv = '0;
    endcase
    clr = (w && a == A_CAP) ? (d[9:0] & wmask(i)) : '0;
    if (r) begin
      case (a)
        A_DATA:  m_rd[i] = 32'(m_stable[i]);
        A_MASK:  m_rd[i] = 32'(m_mask[i]);
        A_CAP:   m_rd[i] = 32'(m_cap[i]);
        default: m_rd[i] = 32'(m_mode[i]);
      endcase
    end
    m_irq[i] = |(m_cap[i] & m_mask[i]);
    m_cap[i] = (m_cap[i] & ~clr) | capv;
    if (w && a == A_MASK) m_mask[i] = d[9:0] & wmask(i);
    if (w && a == A_MODE) m_mode[i] = d[1:0];
    m_prev[i]   = m_stable[i];
    m_stable[i] = ns;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [9:0]  p [2];
    logic        r [2], w [2], rs [2];
    logic [1:0]  a [2];
    logic [31:0] d [2];
    p[0] = {6'b0, pad_a};
    p[1] = pad_b;
    for (int i = 0; i < 2; i++) begin
      r[i]  = rd[i];
      w[i]  = wr[i];
      rs[i] = rst_n[i];
      a[i]  = addr[i];
      d[i]  = wdata[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rs[i]) model_reset(i);
      else model_step(i, p[i], r[i], w[i], a[i], d[i]);
    end
    #1;
    chk("a_readdata", rdata[0], m_rd[0]);
    chk("a_irq", 32'(irq_w[0]), 32'(m_irq[0]));
    chk("b_readdata", rdata[1], m_rd[1]);
    chk("b_irq", 32'(irq_w[1]), 32'(m_irq[1]));
  endtask

  task automatic write_reg(input int i, input logic [1:0] a, input logic [31:0] d);
    wr[i] = 1'b1;
    addr[i] = a;
    wdata[i] = d;
    tick();
    wr[i] = 1'b0;
  endtask

  task automatic read_lit(input int i, input logic [1:0] a, input logic [31:0] exp,
                          input string name);
    rd[i] = 1'b1;
    addr[i] = a;
    tick();
    rd[i] = 1'b0;
    chk(name, rdata[i], exp);
  endtask

  initial begin
    rst_n = 2'b00;
    pad_a = 4'hF;
    pad_b = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wdata[i] = '0;
      model_reset(i);
    end
    repeat (3) tick();
    rst_n = 2'b11;
    repeat (100) tick();
    read_lit(0, A_DATA, 32'h0, "a_data_idle");
    read_lit(0, A_CAP, 32'h0, "a_cap_idle");
    chk("a_irq_idle", 32'(irq_w[0]), 32'h0);

    // 5-cycle glitch on bit 0 must be filtered.
    pad_a[0] = 1'b0;
    repeat (5) tick();
    pad_a[0] = 1'b1;
    repeat (20) tick();
    read_lit(0, A_DATA, 32'h0, "a_data_glitch");
    read_lit(0, A_CAP, 32'h0, "a_cap_glitch");

    // Held press: stable after edge 10, visible in readdata after edge 11.
    pad_a[0] = 1'b0;
    rd[0] = 1'b1;
    addr[0] = A_DATA;
    repeat (10) tick();
    chk("a_data_t10", rdata[0], 32'h0);
    tick();
    chk("a_data_t11", rdata[0], 32'h1);
    addr[0] = A_CAP;
    tick();
    chk("a_cap_t12", rdata[0], 32'h1);
    rd[0] = 1'b0;

    // Interrupt timing on bit 0.
    write_reg(0, A_CAP, 32'h1);
    write_reg(0, A_MASK, 32'h1);
    pad_a[0] = 1'b1;
    repeat (15) tick();
    pad_a[0] = 1'b0;
    repeat (11) tick();
    chk("a_irq_t11", 32'(irq_w[0]), 32'h0);
    tick();
    chk("a_irq_t12", 32'(irq_w[0]), 32'h1);
    write_reg(0, A_CAP, 32'h1);
    chk("a_irq_hold", 32'(irq_w[0]), 32'h1);
    tick();
    chk("a_irq_clr", 32'(irq_w[0]), 32'h0);
    read_lit(0, A_DATA, 32'h1, "a_data_held");

    // Simultaneous read and write returns the pre-write value.
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = A_MASK; wdata[0] = 32'h5;
    tick();
    rd[0] = 1'b0; wr[0] = 1'b0;
    chk("a_rw_old", rdata[0], 32'h1);
    read_lit(0, A_MASK, 32'h5, "a_mask_new");
    write_reg(0, A_MASK, 32'h1);

    // Falling-edge mode on bit 2, then any-edge mode on bit 3.
    write_reg(0, A_MODE, 32'h2);
    pad_a[2] = 1'b0;
    repeat (15) tick();
    read_lit(0, A_CAP, 32'h0, "a_fall_press");
    pad_a[2] = 1'b1;
    repeat (15) tick();
    read_lit(0, A_CAP, 32'h4, "a_fall_release");
    read_lit(0, A_MODE, 32'h2, "a_mode_rd");
    write_reg(0, A_MODE, 32'h3);
    write_reg(0, A_CAP, 32'h4);
    pad_a[3] = 1'b0;
    repeat (15) tick();
    read_lit(0, A_CAP, 32'h8, "a_any_press");
    write_reg(0, A_CAP, 32'h8);
    pad_a[3] = 1'b1;
    repeat (15) tick();
    read_lit(0, A_CAP, 32'h8, "a_any_release");
    write_reg(0, A_MODE, 32'h0);
    read_lit(0, A_CAP, 32'h8, "a_cap_kept");
    write_reg(0, A_MODE, 32'h3);

    // Capture on bit 1 lands in the same cycle as its W1C.
    write_reg(0, A_CAP, 32'hF);
    pad_a[1] = 1'b0;
    repeat (10) tick();
    write_reg(0, A_CAP, 32'h2);
    read_lit(0, A_CAP, 32'h2, "a_collision");
    write_reg(0, A_MASK, 32'h2);
    tick();
    chk("a_irq_bit1", 32'(irq_w[0]), 32'h1);
    read_lit(0, A_DATA, 32'h3, "a_data_two");

    // Asynchronous reset while bit 1 is mid-debounce.
    pad_a[1] = 1'b1;
    repeat (4) tick();
    rst_n[0] = 1'b0;
    model_reset(0);
    #1;
    chk("a_rst_irq", 32'(irq_w[0]), 32'h0);
    chk("a_rst_rdata", rdata[0], 32'h0);
    repeat (2) tick();
    pad_a = 4'hF;
    rst_n[0] = 1'b1;
    repeat (20) tick();
    read_lit(0, A_DATA, 32'h0, "a_data_post_rst");
    read_lit(0, A_CAP, 32'h0, "a_cap_post_rst");

    // Switch bank, debouncer bypassed.
    pad_b = 10'h2A5;
    rd[1] = 1'b1;
    addr[1] = A_DATA;
    repeat (2) tick();
    chk("b_data_t2", rdata[1], 32'h0);
    tick();
    chk("b_data_t3", rdata[1], 32'h2A5);
    rd[1] = 1'b0;
    write_reg(1, A_MASK, 32'h3FF);
    tick();
    chk("b_irq_on", 32'(irq_w[1]), 32'h1);
    pad_b = 10'h15A;
    repeat (4) tick();
    read_lit(1, A_DATA, 32'h15A, "b_data_toggle");
    read_lit(1, A_CAP, 32'h3FF, "b_cap_all");
    rst_n[1] = 1'b0;
    model_reset(1);
    #1;
    chk("b_rst_irq", 32'(irq_w[1]), 32'h0);
    chk("b_rst_rdata", rdata[1], 32'h0);
    tick();
    pad_b = '0;
    rst_n[1] = 1'b1;
    repeat (5) tick();
    read_lit(1, A_DATA, 32'h0, "b_data_post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
